// File: rtl/sort_sequence_builder_if.sv
// Handshake and RAM-port bundle between the sort control FSM, the sequence builder and the three sequence RAMs.
// master = builder side, slave = controller/RAM side.
interface sort_sequence_builder_if #(
    parameter int ADDR_W = 5,
    parameter int HEAD_W = 64,
    parameter int BW_W   = 10
) ();
    logic              start;
    logic [ADDR_W:0]   num_elements;
    logic [ADDR_W:0]   num_nodes;
    logic              busy;
    logic              done;
    logic [BW_W-1:0]   block_width;
    logic [ADDR_W:0]   node_count;
    logic [ADDR_W-1:0] heads_addr;
    logic [HEAD_W-1:0] heads_rdata;
    logic [ADDR_W-1:0] elem_addr;
    logic [ADDR_W-1:0] elem_data;
    logic              elem_wren;
    logic [ADDR_W-1:0] node_addr;
    logic [ADDR_W-1:0] node_data;
    logic              node_wren;

    modport master (
        input  start, num_elements, num_nodes, heads_rdata,
        output busy, done, block_width, node_count, heads_addr,
               elem_addr, elem_data, elem_wren, node_addr, node_data, node_wren
    );

    modport slave (
        output start, num_elements, num_nodes, heads_rdata,
        input  busy, done, block_width, node_count, heads_addr,
               elem_addr, elem_data, elem_wren, node_addr, node_data, node_wren
    );
endinterface

// File: rtl/sort_sequence_builder.sv
// Purpose: one start pulse computes bar width, writes identity element order, compacts valid node indices.
// Latency: floor(SCREEN_W/N)+1 + max(N,1) + max(3M,1) + 1 cycles; heads RAM read latency is one cycle.
// Backpressure: none; RAM writes are fire-and-forget, start is ignored while busy. NODE_SEQ_PAD_EN adds sentinel padding.
module sort_sequence_builder #(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int HEAD_W    = 64,
    parameter int VALID_BIT = 63,
    parameter int SCREEN_W  = 600,
    parameter int BW_W      = 10
) (
    input logic                    clk,
    input logic                    rst,
    sort_sequence_builder_if.master sq
);
    typedef enum logic [2:0] {
        S_IDLE, S_WIDTH, S_ELEM, S_SCAN_ISSUE, S_SCAN_WAIT, S_SCAN_EVAL, S_PAD, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [BW_W:0]   SCREEN_C = (BW_W+1)'(SCREEN_W);
    localparam logic [BW_W-1:0] BW_ONE   = BW_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d, m_q, m_d, idx_q, idx_d, cnt_q, cnt_d;
    logic [BW_W-1:0]   acc_q, acc_d, bw_q, bw_d;
    logic [BW_W:0]     sum;
    logic              scan_end;
    logic [ADDR_W-1:0] heads_addr, elem_addr, elem_data, node_addr, node_data;
    logic              elem_wren, node_wren, done;
    logic [HEAD_W-1:0] head_word;
    logic              head_valid;
    logic              unused_head;

    assign head_word   = sq.heads_rdata;
    assign head_valid  = head_word[VALID_BIT];
    assign unused_head = ^head_word;
    assign sum         = {1'b0, acc_q} + (BW_W+1)'(n_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            bw_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bw_q    <= bw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        m_d        = m_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        bw_d       = bw_q;
        scan_end   = 1'b0;
        heads_addr = '0;
        elem_addr  = '0;
        elem_data  = '0;
        elem_wren  = 1'b0;
        node_addr  = '0;
        node_data  = '0;
        node_wren  = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sq.start) begin
                    // Counts above DEPTH would run off the RAMs; clamp them.
                    n_d     = (sq.num_elements > DEPTH_C) ? DEPTH_C : sq.num_elements;
                    m_d     = (sq.num_nodes > DEPTH_C) ? DEPTH_C : sq.num_nodes;
                    idx_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    bw_d    = '0;
                    state_d = S_WIDTH;
                end
            end
            S_WIDTH: begin
                if (n_q == '0) begin
                    state_d = S_ELEM;
                end else if (sum <= SCREEN_C) begin
                    acc_d = sum[BW_W-1:0];
                    bw_d  = bw_q + BW_ONE;
                end else begin
                    state_d = S_ELEM;
                end
            end
            S_ELEM: begin
                if (n_q == '0) begin
                    state_d = S_SCAN_ISSUE;
                end else begin
                    elem_addr = idx_q[ADDR_W-1:0];
                    elem_data = idx_q[ADDR_W-1:0];
                    elem_wren = 1'b1;
                    if (idx_q == n_q - ONE) begin
                        idx_d   = '0;
                        state_d = S_SCAN_ISSUE;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            S_SCAN_ISSUE: begin
                if (m_q == '0) begin
                    scan_end = 1'b1;
                end else begin
                    heads_addr = idx_q[ADDR_W-1:0];
                    state_d    = S_SCAN_WAIT;
                end
            end
            S_SCAN_WAIT: begin
                heads_addr = idx_q[ADDR_W-1:0];
                state_d    = S_SCAN_EVAL;
            end
            S_SCAN_EVAL: begin
                heads_addr = idx_q[ADDR_W-1:0];
                if (head_valid) begin
                    node_addr = cnt_q[ADDR_W-1:0];
                    node_data = idx_q[ADDR_W-1:0];
                    node_wren = 1'b1;
                    cnt_d     = cnt_q + ONE;
                end
                if (idx_q == m_q - ONE) begin
                    scan_end = 1'b1;
                end else begin
                    idx_d   = idx_q + ONE;
                    state_d = S_SCAN_ISSUE;
                end
            end
`ifdef NODE_SEQ_PAD_EN
            S_PAD: begin
                if (idx_q == DEPTH_C) begin
                    state_d = S_DONE;
                end else begin
                    node_addr = idx_q[ADDR_W-1:0];
                    node_data = '1;
                    node_wren = 1'b1;
                    if (idx_q == DEPTH_C - ONE) state_d = S_DONE;
                    else                        idx_d   = idx_q + ONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (scan_end) begin
`ifdef NODE_SEQ_PAD_EN
            // Padding reuses idx as the write pointer, starting at the first unused slot.
            idx_d   = cnt_d;
            state_d = S_PAD;
`else
            state_d = S_DONE;
`endif
        end
    end

    assign sq.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sq.done        = done;
    assign sq.block_width = bw_q;
    assign sq.node_count  = cnt_q;
    assign sq.heads_addr  = heads_addr;
    assign sq.elem_addr   = elem_addr;
    assign sq.elem_data   = elem_data;
    assign sq.elem_wren   = elem_wren;
    assign sq.node_addr   = node_addr;
    assign sq.node_data   = node_data;
    assign sq.node_wren   = node_wren;
endmodule

// File: tb/tb_sort_sequence_builder.sv
// Directed bench for sort_sequence_builder: heads RAM model, per-pass write logging, reset-abort and start-filtering cases.
module tb_sort_sequence_builder;
    typedef struct {int a; int d; int k;} wr_t;

    logic        clk;
    logic        rst;
    int          tests;
    int          fails;
    logic [63:0] heads [32];

    sort_sequence_builder_if #(.ADDR_W(5), .HEAD_W(64), .BW_W(10)) sq ();

    sort_sequence_builder #(
        .ADDR_W(5), .DEPTH(32), .HEAD_W(64), .VALID_BIT(63), .SCREEN_W(600), .BW_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sq (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) sq.heads_rdata <= heads[sq.heads_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // mode 0: plain pass; 1: extra start pulse while busy; 2: start held high through done.
    task automatic run_pass(input int n, input int m, input logic [31:0] mask, input int mode,
                            input int exp_bw, input int exp_nc, input int w, input int exp_done_k);
        wr_t eq[$];
        wr_t nq[$];
        int  k, done_k, done_n, busy_err, dual, ha_err, elem_err, node_err, cnt, e_cyc, scan_s, j;
        e_cyc  = (n == 0) ? 1 : n;
        scan_s = w + e_cyc + 1;
        k = 0; done_k = 0; done_n = 0; busy_err = 0; dual = 0; ha_err = 0;
        elem_err = 0; node_err = 0;
        @(negedge clk);
        sq.num_elements = 6'(n);
        sq.num_nodes    = 6'(m);
        sq.start        = 1'b1;
        while (done_k == 0 && k < 2000) begin
            @(negedge clk);
            k++;
            if (mode == 0 && k == 1) sq.start = 1'b0;
            if (mode == 1) sq.start = (k == 10);
            if (sq.elem_wren === 1'b1) eq.push_back('{int'(sq.elem_addr), int'(sq.elem_data), k});
            if (sq.node_wren === 1'b1) nq.push_back('{int'(sq.node_addr), int'(sq.node_data), k});
            if (sq.elem_wren === 1'b1 && sq.node_wren === 1'b1) dual++;
            if (sq.done === 1'b1) begin
                done_k = k;
                done_n++;
                if (sq.busy !== 1'b0) busy_err++;
            end else if (sq.busy !== 1'b1) begin
                busy_err++;
            end
            if (k >= scan_s && k < scan_s + 3 * m && int'(sq.heads_addr) != (k - scan_s) / 3) ha_err++;
        end
        check("done_cycle", done_k, exp_done_k);
        check("block_width", sq.block_width, exp_bw);
        check("node_count", sq.node_count, exp_nc);
        check("busy_profile_errors", busy_err, 0);
        check("dual_wren_cycles", dual, 0);
        check("heads_addr_errors", ha_err, 0);
        check("elem_write_count", eq.size(), n);
        foreach (eq[i]) if (eq[i].a != i || eq[i].d != i || eq[i].k != w + 1 + i) elem_err++;
        check("elem_write_errors", elem_err, 0);
        cnt = 0;
        for (int i = 0; i < m; i++) begin
            if (mask[i]) begin
                if (cnt >= nq.size() || nq[cnt].a != cnt || nq[cnt].d != i || nq[cnt].k != scan_s + 3 * i + 2)
                    node_err++;
                cnt++;
            end
        end
        check("node_write_count", nq.size(), exp_nc);
        check("node_write_errors", node_err, 0);
        @(negedge clk);
        check("done_single_pulse", {31'd0, sq.done} + 64'(done_n), 1);
        check("busy_after_done", sq.busy, 1'b0);
        if (mode == 2) begin
            @(negedge clk);
            check("held_start_restarts", sq.busy, 1'b1);
            sq.start = 1'b0;
            j = 1;
            while (sq.done !== 1'b1 && j < 2000) begin
                @(negedge clk);
                j++;
            end
            check("held_second_pass_len", j, exp_done_k);
            check("held_second_bw", sq.block_width, exp_bw);
        end
    endtask

    initial begin
        int k;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        sq.start = 1'b0;
        sq.num_elements = '0;
        sq.num_nodes = '0;
        for (int i = 0; i < 32; i++) heads[i] = 64'(i * 3);
        #1;
        check("rst_busy", sq.busy, 1'b0);
        check("rst_done", sq.done, 1'b0);
        check("rst_elem_wren", sq.elem_wren, 1'b0);
        check("rst_node_wren", sq.node_wren, 1'b0);
        check("rst_block_width", sq.block_width, 0);
        check("rst_node_count", sq.node_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_pass(6, 0, 32'h0, 0, 100, 0, 101, 109);
        run_pass(7, 0, 32'h0, 1, 85, 0, 86, 95);

        for (int i = 0; i < 32; i++) heads[i] = {1'b1, 63'(i)};
        run_pass(32, 32, 32'hFFFF_FFFF, 0, 18, 32, 19, 148);

        for (int i = 0; i < 32; i++) heads[i] = 64'(i * 5);
        heads[1][63] = 1'b1;
        heads[4][63] = 1'b1;
        heads[9][63] = 1'b1;
        heads[15][63] = 1'b1;
        run_pass(0, 12, 32'h0000_0212, 0, 0, 3, 1, 39);

        // Abort mid-scan: N=4 gives 151 width cycles + 4 elem cycles, so idx 1 evaluates at cycle 161.
        @(negedge clk);
        sq.num_elements = 6'd4;
        sq.num_nodes    = 6'd12;
        sq.start        = 1'b1;
        k = 0;
        while (k < 161) begin
            @(negedge clk);
            k++;
            sq.start = 1'b0;
        end
        check("pre_abort_node_wren", sq.node_wren, 1'b1);
        check("pre_abort_node_data", sq.node_data, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", sq.busy, 1'b0);
        check("abort_done", sq.done, 1'b0);
        check("abort_node_wren", sq.node_wren, 1'b0);
        check("abort_elem_wren", sq.elem_wren, 1'b0);
        check("abort_node_count", sq.node_count, 0);
        @(negedge clk);
        rst = 1'b0;

        run_pass(5, 12, 32'h0000_0212, 0, 120, 3, 121, 163);
        run_pass(6, 0, 32'h0, 2, 100, 0, 101, 109);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
